// File: rtl/psram_pkg.sv
// psram_pkg: shared definitions for the QSPI/QPI PSRAM device model.
//   - Opcodes understood by the model
//   - Transaction state enum
//   - Phase lengths (in sck cycles) for the command and address phases
package psram_pkg;

    localparam logic [7:0] OP_QREAD  = 8'hEB;
    localparam logic [7:0] OP_QWRITE = 8'h38;
    localparam logic [7:0] OP_QPI_EN = 8'h35;
    localparam logic [7:0] OP_QPI_EX = 8'hF5;
    localparam logic [7:0] OP_RST_EN = 8'h66;
    localparam logic [7:0] OP_RST    = 8'h99;

    localparam int CMD_SPI_CYC = 8;
    localparam int CMD_QPI_CYC = 2;
    localparam int ADDR_CYC    = 6;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } psram_state_e;

    // Only the read and write opcodes carry an address phase.
    function automatic logic has_addr(input logic [7:0] op);
        return (op == OP_QREAD) || (op == OP_QWRITE);
    endfunction

endpackage

// File: rtl/psram_qspi_model_array.sv
// psram_array: byte-wide storage behind the PSRAM model.
//   clk   : write clock
//   we    : write enable (synchronous)
//   waddr : write byte address
//   wdata : write byte
//   raddr : read byte address
//   rdata : read byte (asynchronous)
module psram_array #(
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/psram_qspi_model.sv
// psram_qspi_model: QSPI/QPI PSRAM device model.
//   sck   : device clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset (memory contents are kept)
//   ce_n  : active-low chip enable; high aborts the transaction at once
//   dio   : 4-bit bidirectional bus, driven only while returning read data
// Supports quad write (0x38), quad fast read (0xEB), reset-enable/reset
// (0x66/0x99). Define PSRAM_QPI_EN to enable QPI mode switching via
// 0x35/0xF5; without it the command phase is always 8-cycle SPI framing.
module psram_qspi_model
    import psram_pkg::*;
#(
    parameter int ADDR_W      = 22,
    parameter int WAIT_CYCLES = 6
) (
    input  logic       sck,
    input  logic       rst_n,
    input  logic       ce_n,
    inout  wire  [3:0] dio
);

    localparam logic [2:0] ADDR_LAST = 3'(ADDR_CYC - 1);
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    psram_state_e      state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic              nib;
    logic [7:0]        cmd, cmd_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [3:0]        hold;
    logic              qpi_mode;
    logic              rst_arm;
    logic [2:0]        cmd_last_cnt;
    logic              cmd_last;
    logic              we;
    logic [7:0]        rdata;
    logic [3:0]        dio_en;
    logic [3:0]        dio_out;

    assign cmd_last_cnt = qpi_mode ? 3'(CMD_QPI_CYC - 1) : 3'(CMD_SPI_CYC - 1);
    assign cmd_nxt      = qpi_mode ? {cmd[3:0], dio} : {cmd[6:0], dio[0]};
    assign cmd_last     = !ce_n && (state == CMD) && (cnt == cmd_last_cnt);
    // Shifting a 24-bit address through an ADDR_W-wide register keeps
    // exactly the low ADDR_W bits once all six nibbles are in.
    assign addr_nxt     = ADDR_W'({addr, dio});

    always_comb begin
        state_nxt = state;
        case (state)
            CMD: begin
                if (cmd_last) begin
                    state_nxt = has_addr(cmd_nxt) ? ADDR : IGNORE;
                end
            end
            ADDR: begin
                if (cnt == ADDR_LAST) begin
                    if (cmd == OP_QWRITE) begin
                        state_nxt = WDATA;
                    end else begin
                        state_nxt = (WAIT_CYCLES == 0) ? RDATA : DUMMY;
                    end
                end
            end
            DUMMY: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = RDATA;
                end
            end
            default: ;
        endcase
        cnt_nxt = (state_nxt != state) ? 3'd0 : cnt + 3'd1;
    end

    // Transaction state: cleared by reset and by ce_n going high.
    always_ff @(posedge sck or negedge rst_n or posedge ce_n) begin
        if (!rst_n) begin
            state <= CMD;
            cnt   <= '0;
            nib   <= 1'b0;
            cmd   <= '0;
            addr  <= '0;
        end else if (ce_n) begin
            state <= CMD;
            cnt   <= '0;
            nib   <= 1'b0;
            cmd   <= '0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            case (state)
                CMD:   cmd  <= cmd_nxt;
                ADDR:  addr <= addr_nxt;
                RDATA, WDATA: begin
                    nib <= ~nib;
                    if (nib) begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // High nibble of a write byte waits here until its low nibble arrives.
    always_ff @(posedge sck) begin
        if (!ce_n && state == WDATA && !nib) begin
            hold <= dio;
        end
    end

    // Mode state survives ce_n; only rst_n clears it.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            rst_arm <= 1'b0;
        end else if (cmd_last) begin
            rst_arm <= (cmd_nxt == OP_RST_EN);
        end
    end

`ifdef PSRAM_QPI_EN
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            qpi_mode <= 1'b0;
        end else if (cmd_last) begin
            if (cmd_nxt == OP_QPI_EN) begin
                qpi_mode <= 1'b1;
            end else if (cmd_nxt == OP_QPI_EX) begin
                qpi_mode <= 1'b0;
            end else if (cmd_nxt == OP_RST && rst_arm) begin
                qpi_mode <= 1'b0;
            end
        end
    end
`else
    assign qpi_mode = 1'b0;
`endif

    assign we = !ce_n && (state == WDATA) && nib;

    psram_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (sck),
        .we   (we),
        .waddr(addr),
        .wdata({hold, dio}),
        .raddr(addr),
        .rdata(rdata)
    );

    assign dio_en  = (state == RDATA) ? 4'hF : 4'h0;
    assign dio_out = nib ? rdata[3:0] : rdata[7:4];
    assign dio     = (dio_en == 4'hF) ? dio_out : 4'bzzzz;

endmodule
